regfile_write_arbiter: RTL

REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

---
 rtl/regfile_write_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
//   Merges two register-file writeback streams (ALU and load unit) onto the
//   single write port of a register file. Each requester owns a one-entry
//   holding register; at most one held entry is granted per cycle and its
//   write is driven combinationally so that the register file write lands on
//   the same edge that drains the entry.
//
// Ports
//   clock, reset          single clock, synchronous active-high reset
//   alu_valid/rd/data     ALU writeback request;  alu_ready = accepted
//   lsu_valid/rd/data     load-unit request;      lsu_ready = accepted
//   RD, WriteData,        register file write index, data and enable
//   RegWrite
//   Read1, Read2          register file read indices for the hazard query
//   hazard                a held, unwritten entry targets nonzero Read1/Read2
//
// Configuration
//   REGFILE_ARB_ROUND_ROBIN_EN  defined: contention alternates between the
//                               requesters using a one-bit last-grant pointer.
//                               undefined: the load unit always wins contention.
//
// Handshake: a request transfers on a rising edge where valid=1 and ready=1.
// ready is combinational: 1 when the requester's entry is empty or is being
// granted (drained) this cycle, and forced to 0 while reset=1. valid may be
// held with changing rd/data until the transfer edge; nothing is latched
// before it.

module regfile_write_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        alu_valid,
  input  logic [5:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,
  input  logic        lsu_valid,
  input  logic [5:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        lsu_ready,
  output logic [5:0]  RD,
  output logic [31:0] WriteData,
  output logic        RegWrite,
  input  logic [5:0]  Read1,
  input  logic [5:0]  Read2,
  output logic        hazard
);

  logic        alu_full;
  logic [5:0]  alu_rd_q;
  logic [31:0] alu_data_q;
  logic        lsu_full;
  logic [5:0]  lsu_rd_q;
  logic [31:0] lsu_data_q;

  logic grant_alu;
  logic grant_lsu;
  logic contention;
  logic alu_wins;
  logic alu_accept;
  logic lsu_accept;

  assign contention = alu_full && lsu_full;

`ifdef REGFILE_ARB_ROUND_ROBIN_EN
  // 1 when the load unit won the most recent contention. Reset value lets
  // the ALU win the first contention after reset.
  logic last_lsu;

  always_ff @(posedge clock) begin
    if (reset) begin
      last_lsu <= 1'b1;
    end else if (contention) begin
      last_lsu <= grant_lsu;
    end
  end

  assign alu_wins = last_lsu;
`else
  assign alu_wins = 1'b0;
`endif

  // Grant selection. Nothing is granted during reset so held writes are
  // discarded rather than written.
  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    if (!reset) begin
      if (contention) begin
        grant_alu = alu_wins;
        grant_lsu = !alu_wins;
      end else begin
        grant_alu = alu_full;
        grant_lsu = lsu_full;
      end
    end
  end

  assign alu_ready  = !reset && (!alu_full || grant_alu);
  assign lsu_ready  = !reset && (!lsu_full || grant_lsu);
  assign alu_accept = alu_valid && alu_ready;
  assign lsu_accept = lsu_valid && lsu_ready;

  // Holding registers: a granted entry may reload on its drain edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      alu_full   <= 1'b0;
      alu_rd_q   <= '0;
      alu_data_q <= '0;
    end else if (alu_accept) begin
      alu_full   <= 1'b1;
      alu_rd_q   <= alu_rd;
      alu_data_q <= alu_data;
    end else if (grant_alu) begin
      alu_full   <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      lsu_full   <= 1'b0;
      lsu_rd_q   <= '0;
      lsu_data_q <= '0;
    end else if (lsu_accept) begin
      lsu_full   <= 1'b1;
      lsu_rd_q   <= lsu_rd;
      lsu_data_q <= lsu_data;
    end else if (grant_lsu) begin
      lsu_full   <= 1'b0;
    end
  end

  // Write port. A granted entry targeting x0 drains silently.
  always_comb begin
    RegWrite  = 1'b0;
    RD        = '0;
    WriteData = '0;
    if (grant_alu && alu_rd_q != 6'd0) begin
      RegWrite  = 1'b1;
      RD        = alu_rd_q;
      WriteData = alu_data_q;
    end else if (grant_lsu && lsu_rd_q != 6'd0) begin
      RegWrite  = 1'b1;
      RD        = lsu_rd_q;
      WriteData = lsu_data_q;
    end
  end

  // An entry being written this cycle still counts as held. The rd != 0
  // term also keeps Read1/Read2 = 0 from ever matching.
  function automatic logic entry_hit(input logic full, input logic [5:0] rd,
                                     input logic [5:0] r1, input logic [5:0] r2);
    return full && (rd != 6'd0) && ((rd == r1) || (rd == r2));
  endfunction

  assign hazard = entry_hit(alu_full, alu_rd_q, Read1, Read2) ||
                  entry_hit(lsu_full, lsu_rd_q, Read1, Read2);

endmodule
